// File: rtl/pixel_point_sink.sv
`default_nettype none
// ============================================================================
// Module      : pixel_point_sink
// Description : Tracks raster position from Frame/Line markers, thresholds
//               pixels into (x,y) edge points and queues them for a consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_point_sink #(
    parameter int COLS   = 10,
    parameter int ROWS   = 10,
    parameter int THRESH = 128,
    parameter int DEPTH  = 8
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic [7:0] Pixel,
    input  logic       Frame,
    input  logic       Line,
    output logic [7:0] PtX,
    output logic [7:0] PtY,
    output logic       PtValid,
    input  logic       PtReady,
    output logic       FrameDone,
    output logic       Overflow,
    output logic       SyncErr
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [7:0]  C_LAST_COL = 8'(COLS - 1);
    localparam logic [7:0]  C_LAST_ROW = 8'(ROWS - 1);
    localparam logic [7:0]  C_THRESH   = 8'(THRESH);
    localparam logic [AW:0] C_DEPTH    = (AW + 1)'(DEPTH);
    localparam logic [AW:0] C_CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE = AW'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [7:0] r_col;
    logic [7:0] r_row;
    logic [7:0] w_col;
    logic [7:0] w_row;
    logic [7:0] w_col_next;
    logic [7:0] w_row_next;
    logic       w_active;
    logic       w_sync_err;
    logic       w_last_pix;

    logic       r_frame_done;
    logic       r_sync_err;
    logic       r_overflow;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_qualify;

    // w_col/w_row hold the marker-corrected position of the current pixel
    always_comb begin
        w_state_next = r_state;
        w_active     = 1'b0;
        w_col        = r_col;
        w_row        = r_row;
        w_sync_err   = 1'b0;
        w_col_next   = r_col;
        w_row_next   = r_row;
        case (r_state)
            S_IDLE: begin
                if (Frame) begin
                    w_state_next = S_RUN;
                    w_active     = 1'b1;
                    w_col        = 8'd0;
                    w_row        = 8'd0;
                end
            end
            S_RUN: begin
                w_active = 1'b1;
                if (Frame) begin
                    w_col      = 8'd0;
                    w_row      = 8'd0;
                    w_sync_err = (r_col != 8'd0) || (r_row != 8'd0);
                end else if (Line) begin
                    if (r_col != 8'd0) begin
                        w_col      = 8'd0;
                        w_row      = (r_row == C_LAST_ROW) ? 8'd0 : r_row + 8'd1;
                        w_sync_err = 1'b1;
                    end else if (r_row == 8'd0) begin
                        // A frame start without Frame is a framing error
                        w_sync_err = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        if (w_col == C_LAST_COL) begin
            w_col_next = 8'd0;
            w_row_next = (w_row == C_LAST_ROW) ? 8'd0 : w_row + 8'd1;
        end else begin
            w_col_next = w_col + 8'd1;
            w_row_next = w_row;
        end
    end

    assign w_last_pix = w_active && (w_col == C_LAST_COL) && (w_row == C_LAST_ROW);
    assign w_qualify  = w_active && (Pixel >= C_THRESH);

    always_ff @(posedge Clk) begin
        if (nReset) begin
            r_state      <= S_IDLE;
            r_col        <= 8'd0;
            r_row        <= 8'd0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_frame_done <= w_last_pix;
            if (w_active) begin
                r_col <= w_col_next;
                r_row <= w_row_next;
            end
            if (w_sync_err) begin
                r_sync_err <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Point FIFO; a pop in the same cycle frees the slot for a push when full
    assign w_full = (r_count == C_DEPTH);
    assign w_pop  = PtValid && PtReady;
    assign w_push = w_qualify && (!w_full || w_pop);
    assign w_drop = w_qualify && w_full && !w_pop;

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_col, w_row};
        end
    end

    always_ff @(posedge Clk) begin
        if (nReset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign PtValid   = (r_count != '0);
    assign PtX       = PtValid ? r_mem[r_rd_ptr][15:8] : 8'd0;
    assign PtY       = PtValid ? r_mem[r_rd_ptr][7:0]  : 8'd0;
    assign FrameDone = r_frame_done;
    assign Overflow  = r_overflow;
    assign SyncErr   = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_pixel_point_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_pixel_point_sink
// Description : Randomised and directed bench for pixel_point_sink with a
//               raster-index reference model and a point scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_point_sink;

    localparam int COLS   = 10;
    localparam int ROWS   = 10;
    localparam int THRESH = 150;
    localparam int DEPTH  = 8;
    localparam int NPIX   = COLS * ROWS;

    logic       Clk = 1'b0;
    logic       nReset = 1'b1;
    logic [7:0] Pixel = 8'd0;
    logic       Frame = 1'b0;
    logic       Line = 1'b0;
    logic       PtReady = 1'b0;
    logic [7:0] PtX;
    logic [7:0] PtY;
    logic       PtValid;
    logic       FrameDone;
    logic       Overflow;
    logic       SyncErr;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: position as a linear raster index
    logic [15:0] sb_q[$];
    int  m_idx  = 0;
    int  m_occ  = 0;
    bit  m_run  = 0;
    bit  m_fd   = 0;
    bit  m_ovf  = 0;
    bit  m_serr = 0;

    pixel_point_sink #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .THRESH (THRESH),
        .DEPTH  (DEPTH)
    ) dut (
        .Clk       (Clk),
        .nReset    (nReset),
        .Pixel     (Pixel),
        .Frame     (Frame),
        .Line      (Line),
        .PtX       (PtX),
        .PtY       (PtY),
        .PtValid   (PtValid),
        .PtReady   (PtReady),
        .FrameDone (FrameDone),
        .Overflow  (Overflow),
        .SyncErr   (SyncErr)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: a handshake seen at the falling edge completes on the next rising edge
    always @(negedge Clk) begin
        if (!nReset && PtValid && PtReady) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_point", 16'd1, 16'd0);
            end else begin
                chk("point_x", {8'd0, PtX}, {8'd0, sb_q[0][15:8]});
                chk("point_y", {8'd0, PtY}, {8'd0, sb_q[0][7:0]});
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic check_flags();
        chk("ptvalid", {15'd0, PtValid}, {15'd0, m_occ > 0});
        chk("framedone", {15'd0, FrameDone}, {15'd0, m_fd});
        chk("overflow", {15'd0, Overflow}, {15'd0, m_ovf});
        chk("syncerr", {15'd0, SyncErr}, {15'd0, m_serr});
    endtask

    // Called just after a rising edge; applies one pixel and advances the model
    task automatic step(input logic [7:0] pix, input logic frm, input logic lin, input logic rdy);
        int pos;
        bit act;
        bit pop;
        Pixel   = pix;
        Frame   = frm;
        Line    = lin;
        PtReady = rdy;
        act = 0;
        pos = m_idx;
        if (!m_run) begin
            if (frm) begin
                m_run = 1;
                act   = 1;
                pos   = 0;
            end
        end else begin
            act = 1;
            if (frm) begin
                if (pos != 0) m_serr = 1;
                pos = 0;
            end else if (lin) begin
                if (pos % COLS != 0) begin
                    m_serr = 1;
                    pos = ((pos / COLS + 1) % ROWS) * COLS;
                end else if (pos == 0) begin
                    m_serr = 1;
                end
            end
        end
        pop  = (m_occ > 0) && rdy;
        m_fd = act && (pos == NPIX - 1);
        if (act) m_idx = (pos + 1) % NPIX;
        if (act && pix >= THRESH) begin
            if (m_occ < DEPTH || pop) begin
                sb_q.push_back({8'(pos % COLS), 8'(pos / COLS)});
                m_occ++;
            end else begin
                m_ovf = 1;
            end
        end
        if (pop) m_occ--;
        @(posedge Clk);
        #1;
        check_flags();
    endtask

    task automatic do_reset();
        nReset  = 1'b1;
        PtReady = 1'b0;
        Frame   = 1'b0;
        Line    = 1'b0;
        @(posedge Clk);
        #1;
        nReset = 1'b0;
        sb_q.delete();
        m_idx = 0; m_occ = 0; m_run = 0; m_fd = 0; m_ovf = 0; m_serr = 0;
        chk("rst_ptx", {8'd0, PtX}, 16'd0);
        chk("rst_pty", {8'd0, PtY}, 16'd0);
        chk("rst_ptvalid", {15'd0, PtValid}, 16'd0);
        chk("rst_framedone", {15'd0, FrameDone}, 16'd0);
        chk("rst_overflow", {15'd0, Overflow}, 16'd0);
        chk("rst_syncerr", {15'd0, SyncErr}, 16'd0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(8'd0, 1'b0, 1'b0, 1'b1);
        chk("scoreboard_empty", 16'(sb_q.size()), 16'd0);
    endtask

    initial begin
        do_reset();

        // Single qualifying pixel at (3,2)
        for (int i = 0; i < NPIX; i++) begin
            step((i == 23) ? 8'd200 : 8'd100, i == 0, i % COLS == 0, 1'b1);
            if (i == 23) begin
                chk("single_valid", {15'd0, PtValid}, 16'd1);
                chk("single_x", {8'd0, PtX}, 16'd3);
                chk("single_y", {8'd0, PtY}, 16'd2);
            end
            if (i == 99) chk("single_framedone", {15'd0, FrameDone}, 16'd1);
        end
        step(8'd100, 1'b0, 1'b0, 1'b1);
        chk("framedone_pulse", {15'd0, FrameDone}, 16'd0);

        // Overflow with consumer stalled, then ordered drain
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(8'd255, i == 0, i % COLS == 0, 1'b0);
            if (i == 7) chk("ovf_before", {15'd0, Overflow}, 16'd0);
            if (i == 8) begin
                chk("ovf_after9", {15'd0, Overflow}, 16'd1);
                chk("ovf_head_x", {8'd0, PtX}, 16'd0);
                chk("ovf_head_y", {8'd0, PtY}, 16'd0);
            end
        end
        for (int i = 12; i < NPIX; i++) step(8'd0, 1'b0, i % COLS == 0, 1'b1);
        chk("ovf_drained", {15'd0, PtValid}, 16'd0);

        // Full FIFO with simultaneous push and pop every cycle
        do_reset();
        for (int i = 0; i < 8; i++) step(8'd255, i == 0, i % COLS == 0, 1'b0);
        for (int i = 8; i < 48; i++) step(8'd255, 1'b0, i % COLS == 0, 1'b1);
        chk("full_stream_no_ovf", {15'd0, Overflow}, 16'd0);
        drain(12);

        // Line marker at predicted column 5 of row 1
        do_reset();
        for (int i = 0; i < 18; i++) begin
            step((i == 15 || i == 16) ? 8'd255 : 8'd0, i == 0,
                 (i % COLS == 0) || (i == 15), 1'b1);
            if (i == 14) chk("sync_before", {15'd0, SyncErr}, 16'd0);
            if (i == 15) begin
                chk("sync_after", {15'd0, SyncErr}, 16'd1);
                chk("sync_pt_x", {8'd0, PtX}, 16'd0);
                chk("sync_pt_y", {8'd0, PtY}, 16'd2);
            end
        end
        drain(4);

        // IDLE ignores pixels, Frame then starts capture
        do_reset();
        for (int i = 0; i < 6; i++) step(8'd255, 1'b0, i == 3, 1'b1);
        chk("idle_no_point", {15'd0, PtValid}, 16'd0);
        chk("idle_no_syncerr", {15'd0, SyncErr}, 16'd0);
        step(8'd255, 1'b1, 1'b1, 1'b0);
        chk("idle_start_x", {8'd0, PtX}, 16'd0);
        chk("idle_start_y", {8'd0, PtY}, 16'd0);

        // Reset mid-frame with three points queued
        do_reset();
        for (int i = 0; i < 6; i++) step((i < 3) ? 8'd255 : 8'd0, i == 0, i == 0, 1'b0);
        chk("queued_three", 16'(m_occ), 16'd3);
        do_reset();
        for (int i = 0; i < 5; i++) step(8'd255, 1'b0, 1'b0, 1'b1);
        chk("post_rst_ignored", {15'd0, PtValid}, 16'd0);

        // Randomised frames with sporadic misplaced Line markers
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < NPIX; i++) begin
                logic [7:0] pix;
                logic lin;
                pix = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(150, 255)) : 8'($urandom_range(0, 255));
                lin = (i % COLS == 0) || (f > 2 && $urandom_range(0, 49) == 0);
                step(pix, i == 0, lin, $urandom_range(0, 3) != 0);
            end
        end
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
